pipe_reg_hs: RTL and testbench
==============================

# pipe_reg_hs

Parametrised elastic pipeline register: DEPTH cascaded stages of WIDTH-bit data with valid/ready handshaking on both sides. It replaces the plain enable-gated register wherever a datapath must absorb downstream back-pressure without dropping or duplicating data, and without a combinational ready path. Each stage is a two-entry skid buffer, so the block sustains one beat per cycle and holds up to 2*DEPTH beats when stalled. A synchronous flush and a registered occupancy count are included.

## Interface
- WIDTH, 4: data width in bits, ≥1
- DEPTH, 2: number of skid stages, ≥1; capacity 2*DEPTH beats
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all stored beats
- in_valid  in  1  upstream beat present
- in_ready  out  1  block can accept; driven from a register (no combinational path from out_ready)
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  downstream payload
- occupancy  out  OCC_W  registered count of beats held, OCC_W = $clog2(2*DEPTH+1)

## Operation
- Handshake: a beat transfers on any rising edge where valid && ready. Strict FIFO order; no loss, no duplication.
- Stage state: main (m_valid, m_data) and skid (s_valid, s_data). Upstream ready = !s_valid. Downstream valid = m_valid, data = m_data.
- Per-stage update, with dn_rdy = downstream ready of the stage:
  - If dn_rdy || !m_valid and s_valid: m ← s, s_valid ← 0.
  - Else if dn_rdy || !m_valid: m_valid ← up_valid; m_data ← up_data when up_valid.
  - Else (main stalled), if up_valid && !s_valid: s ← up, s_valid ← 1.
- Stage 0 upstream = in_*; stage DEPTH-1 downstream = out_*; stage k's downstream is stage k+1's upstream.
- occupancy increments on input handshake, decrements on output handshake, and is unchanged when both occur. Range 0..2*DEPTH.
- flush: at the edge, all m_valid and s_valid ← 0 and occupancy ← 0.
  - An input handshake at the same edge is discarded.
  - An output handshake at the same edge is completed (the consumer saw valid data before the edge).
  - Data registers are not cleared.
- Stable-output rule: while out_valid && !out_ready, out_data and out_valid hold.
- in_ready falls only once stage 0's skid is occupied.

## Timing
- Reset, asynchronous: all m_valid/s_valid = 0, all data = 0, out_valid = 0, out_data = 0, occupancy = 0, in_ready = 1 (also during reset).
- Latency: a beat accepted at edge t, through empty stages with out_ready = 1, gives out_valid = 1 after edge t+DEPTH-1. That is DEPTH register stages, with the first stage capturing at edge t.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Stall fill: with out_ready = 0 and in_valid = 1, in_ready goes 0 after exactly 2*DEPTH accepted beats.
- Release: in_ready returns to 1 no later than DEPTH cycles after out_ready rises.
- Reset mid-operation: all held beats are lost immediately. After reset release, behaviour is identical to power-up.
- Simultaneous in and out handshake when full: not possible, because in_ready = 0.
- Simultaneous in and out handshake when partially full: occupancy is unchanged.

## Structure
- Sub-module skid_stage (WIDTH parameter) implements one stage. The top generates DEPTH instances plus the occupancy counter and flush fan-out.
- No shared-package typedefs are required. OCC_W is a localparam in the top.
- skid_stage has its own flush input so it can be reused standalone.

## Test plan
- Reset: assert rst_n = 0 mid-cycle with beats held → out_valid = 0, occupancy = 0, in_ready = 1 immediately. After release, push 0xA → out_data = 0xA after DEPTH edges.
- Stream (DEPTH = 2): in_data 1..8 on consecutive cycles, out_ready = 1 → out_data 1..8 on consecutive cycles, first one valid 2 cycles after the first accept; occupancy ≤ 2.
- Back-pressure (DEPTH = 2): out_ready = 0, push 1,2,3,… → in_ready = 0 after 4 accepts, occupancy = 4. Set out_ready = 1 → out_data 1,2,3,4 in order, out_data stable throughout the stall.
- Flush: occupancy = 3, then flush = 1 with in_valid = 1 and out_valid && out_ready at the same edge → the output beat is consumed, the input beat is dropped, next cycle occupancy = 0 and out_valid = 0.
- Random stall (DEPTH = 1 and DEPTH = 3, WIDTH = 8): random in_valid/out_ready over 10k cycles → scoreboard order and data match, occupancy matches the model every cycle, and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/pipe_reg_hs_pkg.sv
// rtl/pipe_reg_hs_pkg.sv - shared helpers for the elastic pipeline register
package pipe_reg_hs_pkg;

  // Bits needed to count 0..2*depth held beats.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_hs_skid_stage.sv
// rtl/pipe_reg_hs_skid_stage.sv - two-entry skid buffer with registered upstream ready
module skid_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;

  // Ready comes straight from the skid flag, so no path from dn_ready.
  assign up_ready = !s_valid;
  assign dn_valid = m_valid;
  assign dn_data  = m_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (dn_ready || !m_valid) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else begin
        m_valid <= up_valid;
        if (up_valid) m_data <= up_data;
      end
    end else if (up_valid && !s_valid) begin
      s_valid <= 1'b1;
      s_data  <= up_data;
    end
  end

endmodule

// File: rtl/pipe_reg_hs.sv
// rtl/pipe_reg_hs.sv - DEPTH cascaded skid stages with flush and occupancy count
module pipe_reg_hs
  import pipe_reg_hs_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 2,
  localparam int OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // Element k is the upstream side of stage k and the downstream side of stage k-1.
  logic             chain_valid [DEPTH+1];
  logic             chain_ready [DEPTH+1];
  logic [WIDTH-1:0] chain_data  [DEPTH+1];

  logic             in_hs;
  logic             out_hs;
  logic [OCC_W-1:0] count;

  assign chain_valid[0]     = in_valid;
  assign chain_data[0]      = in_data;
  assign chain_ready[DEPTH] = out_ready;
  assign in_ready           = chain_ready[0];
  assign out_valid          = chain_valid[DEPTH];
  assign out_data           = chain_data[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    skid_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (chain_valid[k]),
      .up_ready (chain_ready[k]),
      .up_data  (chain_data[k]),
      .dn_valid (chain_valid[k+1]),
      .dn_ready (chain_ready[k+1]),
      .dn_data  (chain_data[k+1])
    );
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_hs && !out_hs) begin
      count <= count + OCC_W'(1);
    end else if (!in_hs && out_hs) begin
      count <= count - OCC_W'(1);
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb/tb_pipe_reg_hs.sv - directed and random-stall bench for pipe_reg_hs
module tb_pipe_reg_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] occupancy;

  logic       r_flush;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_reg_hs #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_reg_hs #(.WIDTH(8), .DEPTH(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .flush(r_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_reg_hs #(.WIDTH(8), .DEPTH(3)) dut_d3 (
    .clk(clk), .rst_n(rst_n), .flush(r_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    #20 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 4'h3; tick();
    in_data = 4'h4; tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL held_occ got=%0d exp=2", occupancy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL midrst_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    #4 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1; tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat1_out_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 4'hA) begin
      bad++; $display("FAIL lat2_out got=%b/%h exp=1/a", out_valid, out_data);
    end
    tick();
    total++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL lat_drain got=%b/%0d exp=0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_stream();
    logic [2:0] exp_occ;
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_valid = (k <= 8);
      in_data  = 4'(k);
      tick();
      exp_occ = (k == 1) ? 3'd1 : (k <= 8) ? 3'd2 : (k == 9) ? 3'd1 : 3'd0;
      if (k >= 2 && k <= 9) begin
        total++; if (out_valid !== 1'b1 || out_data !== 4'(k - 1)) begin
          bad++; $display("FAIL stream_out k=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, 4'(k - 1));
        end
      end else begin
        total++; if (out_valid !== 1'b0) begin
          bad++; $display("FAIL stream_idle k=%0d got=%b exp=0", k, out_valid);
        end
      end
      total++; if (occupancy !== exp_occ) begin
        bad++; $display("FAIL stream_occ k=%0d got=%0d exp=%0d", k, occupancy, exp_occ);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k);
      tick();
      total++; if (in_ready !== (k < 4)) begin
        bad++; $display("FAIL bp_in_ready k=%0d got=%b exp=%b", k, in_ready, (k < 4));
      end
      total++; if (occupancy !== ((k < 4) ? 3'(k) : 3'd4)) begin
        bad++; $display("FAIL bp_occ k=%0d got=%0d", k, occupancy);
      end
      if (k >= 2) begin
        total++; if (out_valid !== 1'b1 || out_data !== 4'h1) begin
          bad++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/1", k, out_valid, out_data);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 4'(j)) begin
        bad++; $display("FAIL bp_drain j=%0d got=%b/%h exp=1/%h", j, out_valid, out_data, 4'(j));
      end
      tick();
      if (j == 2) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
      end
    end
    total++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = 4'(k); tick();
    end
    total++; if (occupancy !== 3'd3 || out_valid !== 1'b1 || out_data !== 4'h1) begin
      bad++; $display("FAIL fl_pre got=%0d/%b/%h exp=3/1/1", occupancy, out_valid, out_data);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL fl_post got=%0d/%b/%b exp=0/0/1", occupancy, out_valid, in_ready);
    end
    in_valid = 1'b1; in_data = 4'h5; tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL fl_refill got=%0d/%b exp=1/0", occupancy, out_valid);
    end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin
      bad++; $display("FAIL fl_next got=%b/%h exp=1/5", out_valid, out_data);
    end
    tick();
    total++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL fl_empty got=%b/%0d exp=0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_random();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       ra, rb;
    for (int c = 0; c < 10000; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = 8'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 8'($urandom);
      b_out_ready = 1'($urandom_range(0, 1));
      #1;
      ra = a_in_ready; rb = b_in_ready;
      a_out_ready = ~a_out_ready; b_out_ready = ~b_out_ready;
      #1;
      if (a_in_ready !== ra || b_in_ready !== rb) begin
        total++; bad++; $display("FAIL rnd_comb c=%0d ready changed with out_ready", c);
      end
      a_out_ready = ~a_out_ready; b_out_ready = ~b_out_ready;
      #1;
      if (a_out_valid && a_out_ready) begin
        total++;
        if (qa.size() == 0 || a_out_data !== qa[0]) begin
          bad++; $display("FAIL rnd_d1_data c=%0d got=%h exp=%h", c, a_out_data, (qa.size() != 0) ? qa[0] : 8'hxx);
        end
        if (qa.size() != 0) void'(qa.pop_front());
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
      if (b_out_valid && b_out_ready) begin
        total++;
        if (qb.size() == 0 || b_out_data !== qb[0]) begin
          bad++; $display("FAIL rnd_d3_data c=%0d got=%h exp=%h", c, b_out_data, (qb.size() != 0) ? qb[0] : 8'hxx);
        end
        if (qb.size() != 0) void'(qb.pop_front());
      end
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
      tick();
      total++; if (int'(a_occ) != qa.size() || qa.size() > 2) begin
        bad++; $display("FAIL rnd_d1_occ c=%0d got=%0d exp=%0d", c, a_occ, qa.size());
      end
      total++; if (int'(b_occ) != qb.size() || qb.size() > 6) begin
        bad++; $display("FAIL rnd_d3_occ c=%0d got=%0d exp=%0d", c, b_occ, qb.size());
      end
    end
  endtask

  initial begin
    r_flush = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
